// File: rtl/fifo_word_unpacker_pkg.sv
// Shared types and width derivation for the FIFO word unpacker.
package fifo_word_unpacker_pkg;

    localparam int DEF_IW = 32;
    localparam int DEF_OW = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_OW-1:0] data;
        logic              last;
    } beat_t;

    function automatic int calc_nsub(input int iw, input int ow);
        return iw / ow;
    endfunction

    function automatic int calc_lgsub(input int nsub);
        return $clog2(nsub);
    endfunction

endpackage

// File: rtl/sfifo.sv
// Purpose: generic synchronous FIFO, async (combinational) or registered head read.
// Latency: written word visible at the head the cycle after the write.
// Backpressure: writes dropped while o_full, reads ignored while o_empty.
module sfifo #(
    parameter int BW             = 32,
    parameter int LGFLEN         = 2,
    parameter bit OPT_ASYNC_READ = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [BW-1:0] i_data,
    output logic          o_full,
    input  logic          i_rd,
    output logic [BW-1:0] o_data,
    output logic          o_empty
);

    logic [BW-1:0]   mem [0:(1<<LGFLEN)-1];
    logic [LGFLEN:0] wr_ptr, rd_ptr;
    logic            wr_en, rd_en;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[LGFLEN] != rd_ptr[LGFLEN]) &&
                     (wr_ptr[LGFLEN-1:0] == rd_ptr[LGFLEN-1:0]);
    assign wr_en   = i_wr && !o_full;
    assign rd_en   = i_rd && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + {{LGFLEN{1'b0}}, 1'b1};
            if (rd_en)
                rd_ptr <= rd_ptr + {{LGFLEN{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr[LGFLEN-1:0]] <= i_data;
    end

    generate
        if (OPT_ASYNC_READ) begin : g_async
            assign o_data = mem[rd_ptr[LGFLEN-1:0]];
        end else begin : g_sync
            logic [LGFLEN:0] rd_n;
            logic [BW-1:0]   r_data;
            assign rd_n = rd_ptr + {{LGFLEN{1'b0}}, rd_en};
            // Bypass covers a write landing in the slot that becomes the new head.
            always_ff @(posedge i_clk) begin
                if (wr_en && (wr_ptr == rd_n))
                    r_data <= i_data;
                else
                    r_data <= mem[rd_n[LGFLEN-1:0]];
            end
            assign o_data = r_data;
        end
    endgenerate

endmodule

// File: rtl/fifo_word_unpacker.sv
// Purpose: pops IW-bit FIFO words, emits OW-bit beats MSB-first (UNPACK_LSB_FIRST_EN: LSB-first).
// Latency: first beat valid the cycle after the pop; one beat/clock, no bubble between words.
// Backpressure: beats held stable while !i_ready; no pop until the last beat is accepted.
module fifo_word_unpacker
    import fifo_word_unpacker_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int OW = DEF_OW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_fifo_empty,
    input  logic [IW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_last,
    output logic          o_busy
);

    localparam int NSUB  = calc_nsub(IW, OW);
    localparam int LGSUB = calc_lgsub(NSUB);

    state_t           state, state_n;
    logic [IW-1:0]    sreg, sreg_n, sreg_shifted;
    logic [LGSUB-1:0] cnt, cnt_n;
    logic             r_valid, xfer, ld, cnt_zero;

    assign r_valid  = (state == ST_SHIFT);
    assign cnt_zero = (cnt == '0);
    assign xfer     = r_valid && i_ready;
    // Gating with reset keeps the FIFO from being popped in the reset cycle.
    assign ld       = !i_reset && !i_fifo_empty && (!r_valid || (xfer && cnt_zero));

`ifdef UNPACK_LSB_FIRST_EN
    assign sreg_shifted = {{OW{1'b0}}, sreg[IW-1:OW]};
    assign o_data       = sreg[OW-1:0];
`else
    assign sreg_shifted = {sreg[IW-OW-1:0], {OW{1'b0}}};
    assign o_data       = sreg[IW-1 -: OW];
`endif

    assign o_fifo_rd = ld;
    assign o_valid   = r_valid;
    assign o_last    = r_valid && cnt_zero;
    assign o_busy    = r_valid || !i_fifo_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (ld) begin
                    sreg_n  = i_fifo_data;
                    cnt_n   = LGSUB'(NSUB - 1);
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    if (!cnt_zero) begin
                        sreg_n = sreg_shifted;
                        cnt_n  = cnt - LGSUB'(1);
                    end else if (ld) begin
                        sreg_n = i_fifo_data;
                        cnt_n  = LGSUB'(NSUB - 1);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench: sfifo (async read) feeding the unpacker; directed per-cycle vector table.
module tb_fifo_word_unpacker;
    import fifo_word_unpacker_pkg::*;

    localparam int IW = DEF_IW;
    localparam int OW = DEF_OW;

    logic          clk = 1'b0;
    logic          rst, wr, rdy;
    logic [IW-1:0] wd, fdata;
    logic          full, fempty, fifo_rd;
    logic          vld, last, busy;
    logic [OW-1:0] dat;

    always #5 clk = ~clk;

    sfifo #(.BW(IW), .LGFLEN(2), .OPT_ASYNC_READ(1'b1)) u_fifo (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(wd), .o_full(full),
        .i_rd(fifo_rd), .o_data(fdata), .o_empty(fempty)
    );

    fifo_word_unpacker #(.IW(IW), .OW(OW)) dut (
        .i_clk(clk), .i_reset(rst), .i_fifo_empty(fempty), .i_fifo_data(fdata),
        .o_fifo_rd(fifo_rd), .o_valid(vld), .i_ready(rdy), .o_data(dat),
        .o_last(last), .o_busy(busy)
    );

    typedef struct {
        string         tag;
        logic          rst;
        logic          wr;
        logic [IW-1:0] wd;
        logic          rdy;
        logic          vld;
        beat_t         beat;
        logic          cd;   // compare o_data on this row
        logic          rd;
        logic          busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic row(input string t, input logic r, input logic w, input logic [IW-1:0] d,
                       input logic rd_y, input logic v, input logic [OW-1:0] ed, input logic c,
                       input logic l, input logic p, input logic b);
        vec_t x;
        x.tag = t; x.rst = r; x.wr = w; x.wd = d; x.rdy = rd_y;
        x.vld = v; x.beat.data = ed; x.beat.last = l; x.cd = c; x.rd = p; x.busy = b;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input string tag, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s row %0d: got %h expected %h", tag, name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; wd = '0; rdy = 1'b0;
        //   tag    rst wr data          rdy  vld data  cd last rd busy
        row("reset", 1, 0, 32'h0,        1,   0, 8'h00, 1, 0,  0, 0);
`ifdef UNPACK_LSB_FIRST_EN
        row("lsb",   0, 1, 32'hA1B2C3D4, 1,   0, 8'h00, 0, 0,  0, 0);
        row("lsb",   0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  1, 1);
        row("lsb",   0, 0, 32'h0,        1,   1, 8'hD4, 1, 0,  0, 1);
        row("lsb",   0, 0, 32'h0,        1,   1, 8'hC3, 1, 0,  0, 1);
        row("lsb",   0, 0, 32'h0,        1,   1, 8'hB2, 1, 0,  0, 1);
        row("lsb",   0, 0, 32'h0,        1,   1, 8'hA1, 1, 1,  0, 1);
        row("lsb",   0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  0, 0);
`else
        // single word, then FIFO empty on the last beat
        row("single",0, 1, 32'hA1B2C3D4, 1,   0, 8'h00, 0, 0,  0, 0);
        row("single",0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  1, 1);
        row("single",0, 0, 32'h0,        1,   1, 8'hA1, 1, 0,  0, 1);
        row("single",0, 0, 32'h0,        1,   1, 8'hB2, 1, 0,  0, 1);
        row("single",0, 0, 32'h0,        1,   1, 8'hC3, 1, 0,  0, 1);
        row("single",0, 0, 32'h0,        1,   1, 8'hD4, 1, 1,  0, 1);
        row("single",0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  0, 0);
        // back-to-back words with no bubble
        row("b2b",   0, 1, 32'h01020304, 1,   0, 8'h00, 0, 0,  0, 0);
        row("b2b",   0, 1, 32'h05060708, 1,   0, 8'h00, 0, 0,  1, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h01, 1, 0,  0, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h02, 1, 0,  0, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h03, 1, 0,  0, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h04, 1, 1,  1, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h05, 1, 0,  0, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h06, 1, 0,  0, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h07, 1, 0,  0, 1);
        row("b2b",   0, 0, 32'h0,        1,   1, 8'h08, 1, 1,  0, 1);
        row("b2b",   0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  0, 0);
        // backpressure mid-word and on the last beat with a word waiting
        row("bp",    0, 1, 32'hDEADBEEF, 1,   0, 8'h00, 0, 0,  0, 0);
        row("bp",    0, 1, 32'h0A0B0C0D, 1,   0, 8'h00, 0, 0,  1, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'hDE, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        0,   1, 8'hAD, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        0,   1, 8'hAD, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        0,   1, 8'hAD, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'hAD, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'hBE, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        0,   1, 8'hEF, 1, 1,  0, 1);
        row("bp",    0, 0, 32'h0,        0,   1, 8'hEF, 1, 1,  0, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'hEF, 1, 1,  1, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'h0A, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'h0B, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'h0C, 1, 0,  0, 1);
        row("bp",    0, 0, 32'h0,        1,   1, 8'h0D, 1, 1,  0, 1);
        row("bp",    0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  0, 0);
        // reset after beat 11: 22 must never be accepted, next word starts at 55
        row("rstmid",0, 1, 32'h11223344, 1,   0, 8'h00, 0, 0,  0, 0);
        row("rstmid",0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  1, 1);
        row("rstmid",0, 0, 32'h0,        1,   1, 8'h11, 1, 0,  0, 1);
        row("rstmid",1, 0, 32'h0,        0,   1, 8'h22, 1, 0,  0, 1);
        row("rstmid",0, 1, 32'h55667788, 1,   0, 8'h00, 1, 0,  0, 0);
        row("rstmid",0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  1, 1);
        row("rstmid",0, 0, 32'h0,        1,   1, 8'h55, 1, 0,  0, 1);
        row("rstmid",0, 0, 32'h0,        1,   1, 8'h66, 1, 0,  0, 1);
        row("rstmid",0, 0, 32'h0,        1,   1, 8'h77, 1, 0,  0, 1);
        row("rstmid",0, 0, 32'h0,        1,   1, 8'h88, 1, 1,  0, 1);
        row("rstmid",0, 0, 32'h0,        1,   0, 8'h00, 0, 0,  0, 0);
`endif

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            wr  = vecs[i].wr;
            wd  = vecs[i].wd;
            rdy = vecs[i].rdy;
            #1;
            chk("o_valid",   vecs[i].tag, i, 32'(vld),     32'(vecs[i].vld));
            chk("o_last",    vecs[i].tag, i, 32'(last),    32'(vecs[i].beat.last));
            chk("o_fifo_rd", vecs[i].tag, i, 32'(fifo_rd), 32'(vecs[i].rd));
            chk("o_busy",    vecs[i].tag, i, 32'(busy),    32'(vecs[i].busy));
            chk("rd_empty",  vecs[i].tag, i, 32'(fifo_rd && fempty), 32'd0);
            chk("fifo_full", vecs[i].tag, i, 32'(full),    32'd0);
            if (vecs[i].cd)
                chk("o_data", vecs[i].tag, i, 32'(dat), 32'(vecs[i].beat.data));
        end
        @(negedge clk);
        wr = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
